// File: rtl/io_post_pkg.sv
// Shared constants and types for the I/O-space POST code port.
package io_post_pkg;

    localparam logic [15:0] PORT_POST   = 16'h0080;
    localparam logic [15:0] PORT_STAT   = 16'h0082;
    localparam logic [15:0] PORT_FIFO   = 16'h0084;
    localparam logic [15:0] RD_UNMAPPED = 16'hFFFF;

    typedef enum logic {IDLE, ACK} state_t;

    // Word-aligned port number; bit 0 only selects the byte lane.
    function automatic logic [15:0] port_word(input logic [15:0] adr);
        return {adr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/io_post_fifo.sv
// Small synchronous 8-bit FIFO holding captured POST codes; clear wins over push/pop.
module io_post_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [7:0]                 din,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_post_port.sv
// Wishbone I/O responder: POST code capture FIFO, last-two-code display and status registers.
module io_post_port
    import io_post_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        byte_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic [15:0] post_o,
    output logic        ovf_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic              capture;
    logic [15:0]       port_q;
    logic              we_q;
    logic [7:0]        wbyte_q;
    logic [7:0]        wbyte;
    logic [15:0]       rdata;
    logic [4:0]        cnt5;
    logic              in_ack;
    logic              post_wr, fifo_rd, fifo_clr;
    logic [7:0]        fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;

    assign capture = (state_q == IDLE) && stb_i;
    assign wbyte   = (byte_i && adr_i[0]) ? dat_i[15:8] : dat_i[7:0];
    assign cnt5    = 5'(fifo_count);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (stb_i) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux works on the live bus address so dat_o is ready in the ACK cycle.
    always_comb begin
        rdata = RD_UNMAPPED;
        case (port_word(adr_i))
            PORT_POST: rdata = post_o;
            PORT_STAT: rdata = {ovf_o, 10'b0, fifo_empty, cnt5[3:0]};
            PORT_FIFO: rdata = fifo_empty ? 16'h0000 : {7'b0, 1'b1, fifo_head};
            default:   rdata = RD_UNMAPPED;
        endcase
    end

    // Side effects fire once, on the edge that ends the ACK cycle.
    assign in_ack   = (state_q == ACK);
    assign post_wr  = in_ack && we_q && (port_q == PORT_POST);
    assign fifo_rd  = in_ack && !we_q && (port_q == PORT_FIFO);
    assign fifo_clr = in_ack && we_q && (port_q == PORT_FIFO);
    assign ack_o    = in_ack;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            dat_o   <= 16'h0000;
            post_o  <= 16'h0000;
            ovf_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                we_q  <= we_i;
                dat_o <= we_i ? 16'h0000 : rdata;
            end
            if (post_wr) post_o <= {post_o[7:0], wbyte_q};
            if (fifo_clr)                  ovf_o <= 1'b0;
            else if (post_wr && fifo_full) ovf_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            port_q  <= port_word(adr_i);
            wbyte_q <= wbyte;
        end
    end

    io_post_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (post_wr),
        .pop    (fifo_rd),
        .clr    (fifo_clr),
        .din    (wbyte_q),
        .head   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_io_post_port.sv
// Directed self-checking bench for io_post_port with DEPTH = 8.
module tb_io_post_port;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] adr_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        we_i;
    logic        byte_i;
    logic        stb_i;
    logic        ack_o;
    logic [15:0] post_o;
    logic        ovf_o;

    int passed = 0;
    int total  = 0;

    io_post_port #(.DEPTH(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .we_i   (we_i),
        .byte_i (byte_i),
        .stb_i  (stb_i),
        .ack_o  (ack_o),
        .post_o (post_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // One bus access; a0/a1/a2 are ack_o before the first edge, in the ACK cycle, and after it.
    // With hold=1, stb_i stays high through the ACK cycle.
    task automatic bus(input logic [15:0] adr, input logic we, input logic bt,
                       input logic [15:0] wd, input logic hold,
                       output logic [15:0] rd, output logic a0, output logic a1,
                       output logic a2);
        @(negedge clk_i);
        adr_i = adr; we_i = we; byte_i = bt; dat_i = wd; stb_i = 1'b1;
        #1 a0 = ack_o;
        @(negedge clk_i);
        a1 = ack_o;
        rd = dat_o;
        if (!hold) begin
            stb_i = 1'b0; we_i = 1'b0;
        end
        @(negedge clk_i);
        a2 = ack_o;
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        logic a0, a1, a2;
        rst_ni = 1'b0; stb_i = 1'b0; we_i = 1'b0; byte_i = 1'b0;
        adr_i = 16'h0; dat_i = 16'h0;
        #12;
        total++;
        if ({ack_o, dat_o, post_o, ovf_o} !== 34'h0) begin
            $display("FAIL reset_outputs: got ack=%b dat=%h post=%h ovf=%b, want all 0",
                     ack_o, dat_o, post_o, ovf_o);
        end else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0010) $display("FAIL reset_status: got %h want 0010", rd);
        else passed++;
        total++;
        if ({a0, a1, a2} !== 3'b010)
            $display("FAIL ack_timing: got %b want 010", {a0, a1, a2});
        else passed++;
    endtask

    task automatic test_push_pop;
        logic [15:0] rd;
        logic a0, a1, a2;
        logic [15:0] exp_pop [4];
        exp_pop = '{16'h0111, 16'h0122, 16'h0133, 16'h0000};
        bus(16'h0080, 1'b1, 1'b1, 16'h0011, 1'b0, rd, a0, a1, a2);
        bus(16'h0080, 1'b1, 1'b1, 16'h0022, 1'b0, rd, a0, a1, a2);
        bus(16'h0080, 1'b1, 1'b1, 16'h0033, 1'b0, rd, a0, a1, a2);
        bus(16'h0080, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h2233) $display("FAIL post_read: got %h want 2233", rd);
        else passed++;
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0003) $display("FAIL status_three: got %h want 0003", rd);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            bus(16'h0084, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
            total++;
            if (rd !== exp_pop[i]) $display("FAIL pop_%0d: got %h want %h", i, rd, exp_pop[i]);
            else passed++;
        end
    endtask

    task automatic test_odd_lane;
        logic [15:0] rd;
        logic a0, a1, a2;
        bus(16'h0081, 1'b1, 1'b1, 16'hAB00, 1'b0, rd, a0, a1, a2);
        total++;
        if (post_o !== 16'h33AB) $display("FAIL odd_lane_post: got %h want 33ab", post_o);
        else passed++;
        bus(16'h0084, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h01AB) $display("FAIL odd_lane_pop: got %h want 01ab", rd);
        else passed++;
    endtask

    task automatic test_overflow;
        logic [15:0] rd;
        logic a0, a1, a2;
        int bad;
        for (int i = 1; i <= 9; i++)
            bus(16'h0080, 1'b1, 1'b0, 16'(i), 1'b0, rd, a0, a1, a2);
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h8008) $display("FAIL ovf_status: got %h want 8008", rd);
        else passed++;
        total++;
        if (ovf_o !== 1'b1 || post_o !== 16'h0809)
            $display("FAIL ovf_outputs: got ovf=%b post=%h want ovf=1 post=0809", ovf_o, post_o);
        else passed++;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            bus(16'h0084, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
            total++;
            if (rd !== (16'h0100 | 16'(i)))
                $display("FAIL ovf_pop_%0d: got %h want %h", i, rd, 16'h0100 | 16'(i));
            else passed++;
        end
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h8010) $display("FAIL ovf_sticky: got %h want 8010", rd);
        else passed++;
        bus(16'h0080, 1'b1, 1'b0, 16'h0044, 1'b0, rd, a0, a1, a2);
        bus(16'h0084, 1'b1, 1'b0, 16'h1234, 1'b0, rd, a0, a1, a2);
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0010 || ovf_o !== 1'b0)
            $display("FAIL clear: got status=%h ovf=%b want 0010 ovf=0", rd, ovf_o);
        else passed++;
        total++;
        if (post_o !== 16'h0944) $display("FAIL clear_keeps_post: got %h want 0944", post_o);
        else passed++;
    endtask

    task automatic test_unmapped;
        logic [15:0] rd;
        logic a0, a1, a2;
        bus(16'h03F8, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'hFFFF || a1 !== 1'b1)
            $display("FAIL unmapped_read: got %h ack=%b want ffff ack=1", rd, a1);
        else passed++;
        bus(16'h0300, 1'b1, 1'b0, 16'h00AA, 1'b0, rd, a0, a1, a2);
        total++;
        if (a1 !== 1'b1) $display("FAIL unmapped_write_ack: got %b want 1", a1);
        else passed++;
        bus(16'h0082, 1'b1, 1'b0, 16'h00AA, 1'b0, rd, a0, a1, a2);
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0010 || post_o !== 16'h0944)
            $display("FAIL unmapped_write_effect: got status=%h post=%h want 0010 0944", rd, post_o);
        else passed++;
    endtask

    task automatic test_held_stb;
        logic [15:0] rd;
        logic a0, a1, a2;
        bus(16'h0080, 1'b1, 1'b0, 16'h0055, 1'b0, rd, a0, a1, a2);
        bus(16'h0080, 1'b1, 1'b0, 16'h0066, 1'b0, rd, a0, a1, a2);
        bus(16'h0084, 1'b0, 1'b0, 16'h0, 1'b1, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0155 || {a0, a1, a2} !== 3'b010)
            $display("FAIL held_pop: got %h acks=%b want 0155 acks=010", rd, {a0, a1, a2});
        else passed++;
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0001) $display("FAIL held_count: got %h want 0001", rd);
        else passed++;
    endtask

    task automatic test_reset_mid_ack;
        logic [15:0] rd;
        logic a0, a1, a2;
        bus(16'h0080, 1'b1, 1'b0, 16'h0077, 1'b0, rd, a0, a1, a2);
        @(negedge clk_i);
        adr_i = 16'h0084; we_i = 1'b0; byte_i = 1'b0; stb_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (ack_o !== 1'b1 || dat_o !== 16'h0166)
            $display("FAIL pre_reset_ack: got ack=%b dat=%h want 1 0166", ack_o, dat_o);
        else passed++;
        rst_ni = 1'b0;
        stb_i = 1'b0;
        #1;
        total++;
        if ({ack_o, dat_o, post_o, ovf_o} !== 34'h0)
            $display("FAIL mid_ack_reset: got ack=%b dat=%h post=%h ovf=%b want all 0",
                     ack_o, dat_o, post_o, ovf_o);
        else passed++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus(16'h0082, 1'b0, 1'b0, 16'h0, 1'b0, rd, a0, a1, a2);
        total++;
        if (rd !== 16'h0010) $display("FAIL post_reset_empty: got %h want 0010", rd);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_odd_lane();
        test_overflow();
        test_unmapped();
        test_held_stb();
        test_reset_mid_ack();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
